// File: rtl/id_stage_hz.sv
// -----------------------------------------------------------------------------
// id_stage_hz -- instruction-decode stage of the 5-stage RV32I pipeline.
//
// Decodes the instruction in IF/ID, builds the sign-extended immediate, reads
// the register file, detects load-use hazards and loads the ID/EX register.
//
// Ports:
//   clock, reset          pipeline clock (rising edge), async active-high reset
//   if_id_*               instruction, PC and valid flag coming from IF/ID
//   wb_regwrite/rd/data   register-file write port driven by writeback
//   ex_flush              EX resolved a taken branch/jump: kill the ID slot
//   stall_out             combinational: hold PC and IF/ID this cycle
//   id_ex_*               registered operands, indices, immediate, controls
//
// Parameters:
//   XLEN    datapath width (32 or 64)
//   NREG    architectural registers (16 or 32); higher indices read as 0
//   BYPASS  1 = same-cycle WB write to a read register returns wb_data
// -----------------------------------------------------------------------------
module id_stage_hz #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_instruction,
  input  logic [XLEN-1:0] if_id_pc,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  output logic            stall_out,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [4:0]      id_ex_rd,
  output logic [2:0]      id_ex_funct3,
  output logic            id_ex_funct7b5,
  output logic            id_ex_regwrite,
  output logic            id_ex_memread,
  output logic            id_ex_memwrite,
  output logic            id_ex_memtoreg,
  output logic            id_ex_alusrc,
  output logic            id_ex_branch,
  output logic            id_ex_jump,
  output logic [1:0]      id_ex_aluop,
  output logic            id_ex_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic            branch;
    logic            jump;
    logic [1:0]      aluop;
    logic            illegal;
  } id_ex_t;

  id_ex_t id_ex_d, id_ex_q;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  assign instr   = if_id_instruction;
  assign opcode  = instr[6:0];
  assign rs2_idx = instr[24:20];
  assign rd_idx  = instr[11:7];

  // ---------------------------------------------------------------------------
  // Register file. The read table always has 32 entries so any 5-bit index is
  // legal; x0 and indices at or above NREG are tied to zero, and only real
  // registers 1..NREG-1 get storage and a write decoder.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rf_tbl [32];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rf
      if (gi == 0 || gi >= NREG) begin : g_zero
        assign rf_tbl[gi] = '0;
      end else begin : g_reg
        logic [XLEN-1:0] x_q, x_d;
        always_comb begin
          x_d = x_q;
          if (wb_regwrite && (wb_rd == 5'(gi))) x_d = wb_data;
        end
        always_ff @(posedge clock or posedge reset) begin
          if (reset) x_q <= '0;
          else       x_q <= x_d;
        end
        assign rf_tbl[gi] = x_q;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control decode and immediate selection.
  // ---------------------------------------------------------------------------
  logic        dec_regwrite, dec_memread, dec_memwrite, dec_memtoreg;
  logic        dec_alusrc, dec_branch, dec_jump, dec_illegal;
  logic [1:0]  dec_aluop;
  logic        uses_rs1, uses_rs2;
  logic [31:0] imm32;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_alusrc   = 1'b0;
    dec_branch   = 1'b0;
    dec_jump     = 1'b0;
    dec_illegal  = 1'b0;
    dec_aluop    = 2'b00;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    imm32        = '0;
    rs1_idx      = instr[19:15];
    case (opcode)
      OP_R: begin
        dec_regwrite = 1'b1; dec_aluop = 2'b10;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_I: begin
        dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_aluop = 2'b11;
        uses_rs1 = 1'b1; imm32 = imm_i;
      end
      OP_LOAD: begin
        dec_regwrite = 1'b1; dec_memread = 1'b1; dec_memtoreg = 1'b1;
        dec_alusrc = 1'b1; uses_rs1 = 1'b1; imm32 = imm_i;
      end
      OP_STORE: begin
        dec_memwrite = 1'b1; dec_alusrc = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm32 = imm_s;
      end
      OP_BRANCH: begin
        dec_branch = 1'b1; dec_aluop = 2'b01;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm32 = imm_b;
      end
      OP_LUI: begin
        // rs1 is forced to x0 so EX can compute 0 + imm with the plain adder.
        dec_regwrite = 1'b1; dec_alusrc = 1'b1; imm32 = imm_u;
        rs1_idx = 5'd0;
      end
      OP_AUIPC: begin
        dec_regwrite = 1'b1; dec_alusrc = 1'b1; imm32 = imm_u;
      end
      OP_JAL: begin
        dec_regwrite = 1'b1; dec_jump = 1'b1; imm32 = imm_j;
      end
      OP_JALR: begin
        dec_regwrite = 1'b1; dec_jump = 1'b1; dec_alusrc = 1'b1;
        uses_rs1 = 1'b1; imm32 = imm_i;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand read with optional write-through bypass from WB.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = rf_tbl[rs1_idx];
    rs2_val = rf_tbl[rs2_idx];
    if ((BYPASS != 0) && wb_regwrite && (wb_rd == rs1_idx) && (rs1_idx != 5'd0))
      rs1_val = wb_data;
    if ((BYPASS != 0) && wb_regwrite && (wb_rd == rs2_idx) && (rs2_idx != 5'd0))
      rs2_val = wb_data;
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard: the load in ID/EX produces data the ID instruction needs
  // before it could be forwarded, so a single bubble is inserted.
  // ---------------------------------------------------------------------------
  logic hz;
  assign hz = if_id_valid & id_ex_q.valid & id_ex_q.memread & (id_ex_q.rd != 5'd0) &
              ((uses_rs1 & (id_ex_q.rd == rs1_idx)) | (uses_rs2 & (id_ex_q.rd == rs2_idx)));

  // A flush discards the ID instruction anyway, so holding IF/ID would only
  // block the redirected fetch.
  assign stall_out = hz & ~ex_flush;

  // ---------------------------------------------------------------------------
  // ID/EX register: flush and hazard both produce an all-zero bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    id_ex_d = '0;
    if (!ex_flush && !hz) begin
      id_ex_d.valid    = if_id_valid;
      id_ex_d.pc       = if_id_pc;
      id_ex_d.rs1_data = rs1_val;
      id_ex_d.rs2_data = rs2_val;
      id_ex_d.imm      = XLEN'($signed(imm32));
      id_ex_d.rs1      = rs1_idx;
      id_ex_d.rs2      = rs2_idx;
      id_ex_d.rd       = rd_idx;
      id_ex_d.funct3   = instr[14:12];
      id_ex_d.funct7b5 = instr[30];
      if (if_id_valid) begin
        id_ex_d.regwrite = dec_regwrite;
        id_ex_d.memread  = dec_memread;
        id_ex_d.memwrite = dec_memwrite;
        id_ex_d.memtoreg = dec_memtoreg;
        id_ex_d.alusrc   = dec_alusrc;
        id_ex_d.branch   = dec_branch;
        id_ex_d.jump     = dec_jump;
        id_ex_d.aluop    = dec_aluop;
        id_ex_d.illegal  = dec_illegal;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) id_ex_q <= '0;
    else       id_ex_q <= id_ex_d;
  end

  assign id_ex_valid    = id_ex_q.valid;
  assign id_ex_pc       = id_ex_q.pc;
  assign id_ex_rs1_data = id_ex_q.rs1_data;
  assign id_ex_rs2_data = id_ex_q.rs2_data;
  assign id_ex_imm      = id_ex_q.imm;
  assign id_ex_rs1      = id_ex_q.rs1;
  assign id_ex_rs2      = id_ex_q.rs2;
  assign id_ex_rd       = id_ex_q.rd;
  assign id_ex_funct3   = id_ex_q.funct3;
  assign id_ex_funct7b5 = id_ex_q.funct7b5;
  assign id_ex_regwrite = id_ex_q.regwrite;
  assign id_ex_memread  = id_ex_q.memread;
  assign id_ex_memwrite = id_ex_q.memwrite;
  assign id_ex_memtoreg = id_ex_q.memtoreg;
  assign id_ex_alusrc   = id_ex_q.alusrc;
  assign id_ex_branch   = id_ex_q.branch;
  assign id_ex_jump     = id_ex_q.jump;
  assign id_ex_aluop    = id_ex_q.aluop;
  assign id_ex_illegal  = id_ex_q.illegal;

endmodule
